// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory (IDLE -> ACCESS -> RESP).
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every tie from IDLE.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_id,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a port raises req with stable we/addr/wdata and holds it until it
  // sees its ack, a one-cycle pulse during which its rdata is valid.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                take;
  logic                take_port;
  logic                other_req;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic                last_grant;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    take_port = 1'b0;
    other_req = grant_id ? m0_req : m1_req;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          take      = 1'b1;
          state_nxt = ACCESS;
          if (m0_req && m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            take_port = 1'b0;
`else
            take_port = ~last_grant;
`endif
          end else begin
            take_port = m1_req;
          end
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        // The winner's req is still legally high here, so only the other port competes.
        if (other_req) begin
          take      = 1'b1;
          take_port = ~grant_id;
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = (state == ACCESS) && lat_we;
    m0_ack    = (state == RESP) && !grant_id;
    m1_ack    = (state == RESP) && grant_id;
    busy      = (state != IDLE);
    dbg_state = state;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (take) begin
        grant_id  <= take_port;
        lat_we    <= take_port ? m1_we    : m0_we;
        lat_addr  <= take_port ? m1_addr  : m0_addr;
        lat_wdata <= take_port ? m1_wdata : m0_wdata;
      end
      if (state == ACCESS) begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last_grant <= grant_id;
`endif
        // Captured on writes too: the winner sees the word as it was before the write.
        if (grant_id) m1_rdata <= mem_rdata;
        else          m0_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model (honours DMEM_ARB_FIXED_PRIO_EN).
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m0_ack;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0, m1_ack;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          grant_id, busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_1111);
  endfunction

  // Data memory: 16 words, combinational read, write on the clock edge.
  logic [DW-1:0] mem_arr [0:15];
  logic          mem_loaded = 1'b0;
  assign mem_rdata = mem_arr[mem_addr[5:2]];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      mem_arr[mem_addr[5:2]] <= mem_wdata;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one transaction in flight, age 1 = memory access, age 2 = response.
  int            m_age;
  bit            m_own, m_last, m_we;
  logic [31:0]   m_addr, m_data;
  logic [31:0]   ref_mem [0:15];
  logic [31:0]   exp_rd [2];

  // Requesters
  bit            pend [2];
  bit            rq_we [2];
  logic [31:0]   rq_addr [2], rq_data [2];
  int            rate [2];

  int            ack_log [$];
  int            ack_cyc [$];
  int            cyc = 0;
  int            we_cnt = 0;
  int            busy_low = 0;
  bit            busy_watch = 1'b0;
  int            post_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int log_at(input int i);
    return (i < ack_log.size()) ? ack_log[i] : -1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < ack_cyc.size()) ? ack_cyc[i] : -100;
  endfunction

  task automatic drive();
    m0_req = pend[0]; m0_we = rq_we[0]; m0_addr = rq_addr[0]; m0_wdata = rq_data[0];
    m1_req = pend[1]; m1_we = rq_we[1]; m1_addr = rq_addr[1]; m1_wdata = rq_data[1];
  endtask

  task automatic post(input int p, input bit we, input logic [31:0] addr, input logic [31:0] data);
    pend[p] = 1'b1; rq_we[p] = we; rq_addr[p] = addr; rq_data[p] = data;
    post_cyc = cyc;
  endtask

  task automatic model_grant(input int p);
    m_own = p[0]; m_we = rq_we[p]; m_addr = rq_addr[p]; m_data = rq_data[p]; m_age = 1;
  endtask

  task automatic model_reset();
    m_age = 0; m_own = 1'b0; m_last = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive();
  endtask

  task automatic model_advance();
    int other;
    other = m_own ? 0 : 1;
    if (m_age == 1) begin
      m_last = m_own;
      exp_rd[m_own] = ref_mem[m_addr[5:2]];
      if (m_we) ref_mem[m_addr[5:2]] = m_data;
      m_age = 2;
    end else if (m_age == 2) begin
      if (pend[other]) model_grant(other);
      else m_age = 0;
    end else if (pend[0] || pend[1]) begin
      if (pend[0] && pend[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        model_grant(0);
`else
        model_grant(m_last ? 0 : 1);
`endif
      end else begin
        model_grant(pend[1] ? 1 : 0);
      end
    end
  endtask

  // One clock: check outputs at the falling edge, react to acks, drive, advance model.
  task automatic step();
    bit ack [2];
    @(negedge clk);
    ack[0] = m0_ack; ack[1] = m1_ack;
    chk("busy", 32'(busy), 32'(m_age != 0));
    chk("grant_id", 32'(grant_id), 32'(m_own));
    chk("mem_we", 32'(mem_we), 32'((m_age == 1) && m_we));
    chk("m0_ack", 32'(m0_ack), 32'((m_age == 2) && !m_own));
    chk("m1_ack", 32'(m1_ack), 32'((m_age == 2) && m_own));
    chk("m0_rdata", m0_rdata, exp_rd[0]);
    chk("m1_rdata", m1_rdata, exp_rd[1]);
    if (m_age == 1) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_data);
    end
    if (mem_we === 1'b1) we_cnt++;
    if (busy_watch && busy !== 1'b1) busy_low++;
    for (int p = 0; p < 2; p++) begin
      if (ack[p]) begin
        ack_log.push_back(p);
        ack_cyc.push_back(cyc);
      end
      if (pend[p] && ack[p]) begin
        pend[p] = 1'b0;
      end else if (!pend[p] && rate[p] > 0 && $urandom_range(0, 99) < rate[p]) begin
        pend[p] = 1'b1;
        rq_we[p] = 1'($urandom_range(0, 1));
        rq_addr[p] = 32'($urandom_range(0, 15)) << 2;
        rq_data[p] = $urandom;
      end
    end
    drive();
    model_advance();
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend[0] || pend[1] || m_age != 0) && n < 60) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < 60), 32'd1);
  endtask

  task automatic clear_log();
    ack_log.delete();
    ack_cyc.delete();
    we_cnt = 0;
  endtask

  initial begin
    int p0;
    int first;
    int n;
    logic [31:0] saved;
    logic [31:0] d;

    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    rate[0] = 0; rate[1] = 0;
    rq_we[0] = 1'b0; rq_we[1] = 1'b0;
    rq_addr[0] = '0; rq_addr[1] = '0; rq_data[0] = '0; rq_data[1] = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_rdata0", m0_rdata, 32'd0);
    chk("rst_rdata1", m1_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;

    // Simultaneous first request: m0 then m1, two cycles apart
    clear_log();
    post(0, 1'b0, 32'h4, 32'h0);
    post(1, 1'b0, 32'h8, 32'h0);
    drain();
    chk("tie_count", 32'(ack_log.size()), 32'd2);
    chk("tie_first", 32'(log_at(0)), 32'd0);
    chk("tie_second", 32'(log_at(1)), 32'd1);
    chk("tie_gap", 32'(cyc_at(1) - cyc_at(0)), 32'd2);

    // Single write then read on m0
    clear_log();
    post(0, 1'b1, 32'h10, 32'hDEADBEEF);
    p0 = post_cyc;
    drain();
    chk("wr_we_cycles", 32'(we_cnt), 32'd1);
    chk("wr_ack_latency", 32'(cyc_at(0) - p0), 32'd2);
    post(0, 1'b0, 32'h10, 32'h0);
    step();
    chk("rd_m0_rdata_early", m0_rdata, init_word(4));
    drain();
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_acks", 32'(ack_log.size()), 32'd2);
    chk("rd_no_m1_ack", 32'((log_at(0) == 1) || (log_at(1) == 1)), 32'd0);

    // Tie from IDLE after a port-0 transaction
    clear_log();
    post(0, 1'b0, 32'h0, 32'h0);
    post(1, 1'b0, 32'h4, 32'h0);
    drain();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    chk("idle_tie_winner", 32'(log_at(0)), 32'd0);
`else
    chk("idle_tie_winner", 32'(log_at(0)), 32'd1);
`endif

    // Continuous contention: 8 transactions alternate, busy stays high
    clear_log();
    busy_low = 0;
    rate[0] = 100; rate[1] = 100;
    n = 0;
    while (ack_log.size() < 8 && n < 100) begin
      step();
      if (ack_log.size() >= 1) busy_watch = 1'b1;
      n++;
    end
    busy_watch = 1'b0;
    rate[0] = 0; rate[1] = 0;
    chk("cont_timeout", 32'(n < 100), 32'd1);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    first = 0;
`else
    first = 1;
`endif
    for (int i = 0; i < 8; i++) chk("cont_order", 32'(log_at(i)), 32'(first ^ (i % 2)));
    chk("cont_busy_low", 32'(busy_low), 32'd0);
    drain();

    // Back-to-back on m1 with m0 idle: one IDLE cycle between transactions
    clear_log();
    d = $urandom;
    post(1, 1'b1, 32'h30, d);
    drain();
    post(1, 1'b0, 32'h30, 32'h0);
    drain();
    chk("b2b_gap", 32'(cyc_at(1) - cyc_at(0)), 32'd3);
    chk("b2b_rdata", m1_rdata, d);

    // Reset during ACCESS of a write to 0x20
    clear_log();
    saved = ref_mem[8];
    post(0, 1'b1, 32'h20, 32'h12345678);
    step();
    @(posedge clk);
    #1;
    chk("rstmid_we_before", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_we_drop", 32'(mem_we), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ack", 32'(m0_ack), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    chk("rstmid_no_ack", 32'(ack_log.size()), 32'd0);
    post(0, 1'b0, 32'h20, 32'h0);
    drain();
    chk("rstmid_rd", m0_rdata, saved);

    // Random traffic
    rate[0] = 35; rate[1] = 35;
    repeat (400) step();
    rate[0] = 0; rate[1] = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
